kp_req_source: RTL and testbench
================================

KP_REQ_SOURCE -- requirements
Module: kp_req_source

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- DATA_WIDTH, 16, pixel width (RGB565).
- LINE_LENGTH, 480, pixels per line.
- LINE_COUNT, 480, lines per frame.
- FIFO_DEPTH, 16, upstream buffer entries (power of 2).
REQ-002 SHALL have ports (name  direction  width  meaning), one per line; one clock; reset is synchronous and active-low:
- i_clk  in  1  sole clock, rising edge.
- i_rstn  in  1  synchronous active-low reset.
- i_data  in  DATA_WIDTH  upstream pixel.
- i_valid  in  1  upstream pixel valid.
- i_sof  in  1  upstream first pixel of frame, qualified by i_valid.
- o_ready  out  1  upstream may write.
- i_req  in  1  downstream kernel-control pixel request.
- o_data  out  DATA_WIDTH  served pixel.
- o_valid  out  1  o_data valid.
- o_sol / o_eol  out  1  served pixel is column 0 / LINE_LENGTH-1.
- o_sof / o_eof  out  1  served pixel is first / last pixel of frame.
- i_clr_status  in  1  clears sticky flags.
- o_underrun  out  1  sticky: request served while FIFO empty.
- o_frame_err  out  1  sticky: i_sof accepted mid-frame.

Function
REQ-003 SHALL write the FIFO when i_valid && o_ready; o_ready = FIFO not full, combinational from registered occupancy.
REQ-004 SHALL answer i_req high in cycle N with o_valid=1 and o_data in cycle N+1 (registered, exactly one pixel per request); o_valid=0 and o_data=0 in cycles without a preceding request.
REQ-005 SHALL use FSM states SYNC and RUN; reset enters SYNC.
REQ-006 In SYNC: discard upstream pixels until an accepted pixel with i_sof=1; that pixel SHALL be written and the FSM SHALL move to RUN. Requests in SYNC SHALL be treated as underrun (REQ-008).
REQ-007 In RUN: pop one entry per request; column counter 0..LINE_LENGTH-1 wraps, incrementing the row counter 0..LINE_COUNT-1, which wraps to 0 after the eof pixel.
REQ-008 A request with the FIFO empty (including a same-cycle write into an empty FIFO; no fall-through) SHALL serve the last served pixel (0 if none since reset), assert o_valid, set o_underrun, and still advance the counters.
REQ-009 An accepted i_sof pixel in RUN while the column or row counter is nonzero SHALL flush the FIFO, set o_frame_err, zero the counters, and write that pixel as the new first entry.
REQ-010 o_sol/o_eol/o_sof/o_eof SHALL be aligned with o_valid and derived from the pre-increment counters.
REQ-011 i_clr_status SHALL clear the sticky flags; a same-cycle set SHALL win.
REQ-012 A simultaneous push and pop on a non-empty, non-full FIFO SHALL leave the occupancy unchanged.

Reset
REQ-013 While i_rstn=0 on a clock edge: all outputs 0 except o_ready=0, FIFO empty, counters 0, FSM=SYNC; o_ready=1 from the first cycle after release.

Configuration
REQ-014 With KP_REQ_SOURCE_TESTPAT_EN defined: extra input i_testpat (1 bit); while it is high, o_data = {row[7:0], col[7:0]}, the FIFO SHALL NOT be popped, underrun SHALL NOT be flagged, the FSM SHALL be forced to RUN, and the counters SHALL behave as in REQ-007. Without the macro: no port and no pattern logic.

Structure
REQ-015 Package kp_pkg SHALL hold the DATA_WIDTH/LINE_LENGTH/LINE_COUNT defaults and the FSM state enum.
REQ-016 The FIFO SHALL be the sub-module kp_sync_fifo (synchronous, full/empty/count outputs).

Verification
REQ-017 After reset, feed sof pixel 0x1234 then 0x0001..0x000F; request every cycle -> o_data 0x1234 one cycle after the first request with o_sof=o_sol=1, then the data in order.
REQ-018 Fill with 16 pixels and no requests -> o_ready=0 after the 16th; a 17th pixel held on i_valid SHALL NOT be written.
REQ-019 Request with an empty FIFO after serving 0xBEEF -> o_data=0xBEEF, o_valid=1, o_underrun=1 until i_clr_status.
REQ-020 Full 480x480 frame with random requests -> o_eol on every 480th pixel, o_eof on pixel 230400, then the row counter wraps to 0.
REQ-021 i_sof at column 100 -> o_frame_err=1, FIFO flushed, next served pixel has o_sof=1.
REQ-022 With the macro defined, i_testpat=1, requests for 481 pixels -> o_data 0x0000..0x00DF (col[7:0] wraps), then 0x0100 at row 1.

Source files
------------

// File: rtl/kp_req_source_pkg.sv
// kp_pkg: shared defaults, FSM state type and counter sizing helper for the
// kp_req_source pixel request source.
package kp_pkg;

    localparam int KP_DATA_WIDTH  = 16;
    localparam int KP_LINE_LENGTH = 480;
    localparam int KP_LINE_COUNT  = 480;
    localparam int KP_FIFO_DEPTH  = 16;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } kp_state_e;

    // Counters are at least 8 bits wide so the test pattern can always take [7:0].
    function automatic int kp_cnt_width(input int n);
        int w;
        w = (n > 1) ? $clog2(n) : 1;
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/kp_req_source_if.sv
// kp_req_source_if: upstream write port, downstream request port and status
// flags of kp_req_source. The design takes the slave modport.
interface kp_req_source_if import kp_pkg::*; #(
    parameter int DATA_WIDTH = KP_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_valid;
    logic                  i_sof;
    logic                  o_ready;
    logic                  i_req;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  o_sol;
    logic                  o_eol;
    logic                  o_sof;
    logic                  o_eof;
    logic                  i_clr_status;
    logic                  o_underrun;
    logic                  o_frame_err;

    modport master (
        output i_data, i_valid, i_sof, i_req, i_clr_status,
        input  o_ready, o_data, o_valid, o_sol, o_eol, o_sof, o_eof,
               o_underrun, o_frame_err
    );

    modport slave (
        input  i_data, i_valid, i_sof, i_req, i_clr_status,
        output o_ready, o_data, o_valid, o_sol, o_eol, o_sof, o_eof,
               o_underrun, o_frame_err
    );

endinterface

// File: rtl/kp_sync_fifo.sv
// kp_sync_fifo: single-clock FIFO with a flush that can restart the queue
// with a same-cycle write as its only entry. Read data is the head entry
// (look-ahead), valid whenever empty is low.
module kp_sync_fifo import kp_pkg::*; #(
    parameter int DATA_WIDTH = KP_DATA_WIDTH,
    parameter int DEPTH      = KP_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic                   push,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   pop,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Next pointers, occupancy and storage; a flush discards everything first.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            if (push) begin
                mem_d[0] = wr_data;
                wr_ptr_d = AW'(1);
                count_d  = (AW+1)'(1);
            end
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below the occupancy.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/kp_req_source.sv
// kp_req_source: buffers an upstream pixel stream and serves one pixel per
// downstream request, one cycle later, with line/frame position flags.
// Optional test pattern generator: define KP_REQ_SOURCE_TESTPAT_EN.
module kp_req_source import kp_pkg::*; #(
    parameter int DATA_WIDTH  = KP_DATA_WIDTH,
    parameter int LINE_LENGTH = KP_LINE_LENGTH,
    parameter int LINE_COUNT  = KP_LINE_COUNT,
    parameter int FIFO_DEPTH  = KP_FIFO_DEPTH
) (
    input  logic i_clk,
    input  logic i_rstn,
`ifdef KP_REQ_SOURCE_TESTPAT_EN
    input  logic i_testpat,
`endif
    kp_req_source_if.slave bus
);

    localparam int COL_W = kp_cnt_width(LINE_LENGTH);
    localparam int ROW_W = kp_cnt_width(LINE_COUNT);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LENGTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(LINE_COUNT - 1);

    kp_state_e             state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [DATA_WIDTH-1:0] last_q, last_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  sol_q, sol_d, eol_q, eol_d;
    logic                  sof_q, sof_d, eof_q, eof_d;
    logic                  underrun_q, underrun_d;
    logic                  frame_err_q, frame_err_d;
    logic                  ready_en_q;

    logic                       ready, accept, at_origin, restart, pattern_on;
    logic                       underrun_set, frame_err_set;
    logic                       fifo_push, fifo_pop, fifo_flush;
    logic                       fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0]      fifo_rd_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                       unused_fifo_count;

    kp_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rstn    (i_rstn),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .wr_data (bus.i_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign unused_fifo_count = ^fifo_count;

    assign ready     = ready_en_q && !fifo_full;
    assign accept    = bus.i_valid && ready;
    assign at_origin = (col_q == '0) && (row_q == '0);

`ifdef KP_REQ_SOURCE_TESTPAT_EN
    assign pattern_on = i_testpat;
`else
    assign pattern_on = 1'b0;
`endif

    // FSM, FIFO control, served pixel, position counters and sticky flags.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        last_d        = last_q;
        data_d        = '0;
        valid_d       = 1'b0;
        sol_d         = 1'b0;
        eol_d         = 1'b0;
        sof_d         = 1'b0;
        eof_d         = 1'b0;
        underrun_d    = underrun_q;
        frame_err_d   = frame_err_q;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        fifo_flush    = 1'b0;
        restart       = 1'b0;
        underrun_set  = 1'b0;
        frame_err_set = 1'b0;

        if (pattern_on) begin
            state_d = RUN;
        end

        if ((state_q == SYNC) && !pattern_on) begin
            if (accept && bus.i_sof) begin
                fifo_push = 1'b1;
                restart   = 1'b1;
                state_d   = RUN;
            end
        end else if (accept) begin
            fifo_push = 1'b1;
            if (bus.i_sof && !at_origin) begin
                fifo_flush    = 1'b1;
                frame_err_set = 1'b1;
                restart       = 1'b1;
            end
        end

        if (bus.i_req) begin
            valid_d = 1'b1;
            sol_d   = (col_q == '0);
            eol_d   = (col_q == LAST_COL);
            sof_d   = (col_q == '0) && (row_q == '0);
            eof_d   = (col_q == LAST_COL) && (row_q == LAST_ROW);
            data_d  = last_q;
            if (pattern_on) begin
`ifdef KP_REQ_SOURCE_TESTPAT_EN
                data_d = DATA_WIDTH'({row_q[7:0], col_q[7:0]});
`endif
            end else if ((state_q == RUN) && !fifo_empty) begin
                fifo_pop = 1'b1;
                data_d   = fifo_rd_data;
            end else begin
                underrun_set = 1'b1;
            end
            last_d = data_d;
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        // A new frame start overrides any advance from a same-cycle request.
        if (restart) begin
            col_d = '0;
            row_d = '0;
        end

        if (bus.i_clr_status) begin
            underrun_d  = 1'b0;
            frame_err_d = 1'b0;
        end
        if (underrun_set) begin
            underrun_d = 1'b1;
        end
        if (frame_err_set) begin
            frame_err_d = 1'b1;
        end
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= SYNC;
            col_q       <= '0;
            row_q       <= '0;
            last_q      <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sol_q       <= 1'b0;
            eol_q       <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            last_q      <= last_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sol_q       <= sol_d;
            eol_q       <= eol_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
            ready_en_q  <= 1'b1;
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_sol       = sol_q;
    assign bus.o_eol       = eol_q;
    assign bus.o_sof       = sof_q;
    assign bus.o_eof       = eof_q;
    assign bus.o_underrun  = underrun_q;
    assign bus.o_frame_err = frame_err_q;

endmodule

// File: tb/tb_kp_req_source.sv
// tb_kp_req_source: directed bench for kp_req_source. A 480x480 instance covers
// streaming, back-pressure, underrun and frame errors; a 4x3 instance covers a
// complete frame and the row wrap. Define KP_REQ_SOURCE_TESTPAT_EN to also
// exercise the test pattern.
module tb_kp_req_source;

    logic clk = 1'b0;
    logic rstn;
    int   num_compared;
    int   num_mismatched;
`ifdef KP_REQ_SOURCE_TESTPAT_EN
    logic testpat;
    logic small_testpat;
`endif

    kp_req_source_if #(.DATA_WIDTH(16)) bus ();
    kp_req_source_if #(.DATA_WIDTH(16)) sbus ();

    kp_req_source #(
        .DATA_WIDTH  (16),
        .LINE_LENGTH (480),
        .LINE_COUNT  (480),
        .FIFO_DEPTH  (16)
    ) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
`ifdef KP_REQ_SOURCE_TESTPAT_EN
        .i_testpat (testpat),
`endif
        .bus       (bus)
    );

    kp_req_source #(
        .DATA_WIDTH  (16),
        .LINE_LENGTH (4),
        .LINE_COUNT  (3),
        .FIFO_DEPTH  (16)
    ) dut_small (
        .i_clk     (clk),
        .i_rstn    (rstn),
`ifdef KP_REQ_SOURCE_TESTPAT_EN
        .i_testpat (small_testpat),
`endif
        .bus       (sbus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive the large instance for one cycle; outputs are stable on return.
    task automatic apply_stimulus(input logic valid, input logic [15:0] data,
                                  input logic sof, input logic req, input logic clr);
        bus.i_valid      = valid;
        bus.i_data       = data;
        bus.i_sof        = sof;
        bus.i_req        = req;
        bus.i_clr_status = clr;
        @(posedge clk);
        #1;
    endtask

    // Same for the small-frame instance.
    task automatic apply_small(input logic valid, input logic [15:0] data,
                               input logic sof, input logic req);
        sbus.i_valid      = valid;
        sbus.i_data       = data;
        sbus.i_sof        = sof;
        sbus.i_req        = req;
        sbus.i_clr_status = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        num_compared   = 0;
        num_mismatched = 0;
        rstn           = 1'b0;
`ifdef KP_REQ_SOURCE_TESTPAT_EN
        testpat       = 1'b0;
        small_testpat = 1'b0;
`endif
        sbus.i_valid = 1'b0; sbus.i_data = '0; sbus.i_sof = 1'b0;
        sbus.i_req = 1'b0; sbus.i_clr_status = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 16'h5A5A, 1'b1, 1'b1, 1'b0);
        check_output("rst_ready", bus.o_ready, 0);
        check_output("rst_valid", bus.o_valid, 0);
        check_output("rst_data", bus.o_data, 0);
        check_output("rst_sof", bus.o_sof, 0);
        check_output("rst_underrun", bus.o_underrun, 0);
        check_output("rst_frame_err", bus.o_frame_err, 0);
        rstn = 1'b1;
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        check_output("ready_after_rst", bus.o_ready, 1);
        check_output("small_ready_after_rst", sbus.o_ready, 1);

        // Stream: sof pixel 0x1234 then 1..F, one request per cycle
        apply_stimulus(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        check_output("stream_idle_valid", bus.o_valid, 0);
        for (int k = 1; k <= 15; k++) begin
            apply_stimulus(1'b1, 16'(k), 1'b0, 1'b1, 1'b0);
            check_output($sformatf("stream_data_%0d", k), bus.o_data,
                         (k == 1) ? 32'h1234 : 32'(k - 1));
            check_output($sformatf("stream_valid_%0d", k), bus.o_valid, 1);
            check_output($sformatf("stream_sof_%0d", k), bus.o_sof, (k == 1) ? 1 : 0);
            check_output($sformatf("stream_sol_%0d", k), bus.o_sol, (k == 1) ? 1 : 0);
        end
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        check_output("stream_last", bus.o_data, 32'h000F);
        check_output("stream_no_underrun", bus.o_underrun, 0);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        check_output("noreq_valid", bus.o_valid, 0);
        check_output("noreq_data", bus.o_data, 0);

        // Underrun repeats the last served pixel; sticky until cleared, set wins
        apply_stimulus(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        check_output("beef_served", bus.o_data, 32'hBEEF);
        check_output("beef_no_underrun", bus.o_underrun, 0);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        check_output("underrun_data", bus.o_data, 32'hBEEF);
        check_output("underrun_valid", bus.o_valid, 1);
        check_output("underrun_flag", bus.o_underrun, 1);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        check_output("underrun_sticky", bus.o_underrun, 1);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        check_output("underrun_cleared", bus.o_underrun, 0);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        check_output("underrun_set_wins", bus.o_underrun, 1);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        check_output("underrun_cleared2", bus.o_underrun, 0);

        // Fill to full, reject a held 17th pixel, push+pop keeps occupancy
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0);
            check_output($sformatf("fill_ready_%0d", i), bus.o_ready, (i < 15) ? 1 : 0);
        end
        apply_stimulus(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
        check_output("full_held_ready", bus.o_ready, 0);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        check_output("full_pop_data", bus.o_data, 32'h0100);
        check_output("full_pop_ready", bus.o_ready, 1);
        apply_stimulus(1'b1, 16'h0110, 1'b0, 1'b1, 1'b0);
        check_output("pushpop_data", bus.o_data, 32'h0101);
        check_output("pushpop_ready", bus.o_ready, 1);
        apply_stimulus(1'b1, 16'h0111, 1'b0, 1'b0, 1'b0);
        check_output("refull_ready", bus.o_ready, 0);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
            check_output($sformatf("drain_%0d", i), bus.o_data, 32'h0102 + 32'(i));
        end
        check_output("drain_no_underrun", bus.o_underrun, 0);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        check_output("drain_underrun_data", bus.o_data, 32'h0111);
        check_output("drain_underrun_flag", bus.o_underrun, 1);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Line end: 38 pixels served so far, continue to column 479
        for (int c = 38; c < 478; c++) apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        check_output("col478_eol", bus.o_eol, 0);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        check_output("col479_eol", bus.o_eol, 1);
        check_output("col479_sol", bus.o_sol, 0);
        check_output("col479_eof", bus.o_eof, 0);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        check_output("row1_sol", bus.o_sol, 1);
        check_output("row1_eol", bus.o_eol, 0);
        check_output("row1_sof", bus.o_sof, 0);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Early sof at column 100 of row 1 flushes and restarts the frame
        for (int c = 1; c < 100; c++) apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b1, 16'h0AAA, 1'b0, 1'b0, 1'b0);
        check_output("pre_sof_frame_err", bus.o_frame_err, 0);
        apply_stimulus(1'b1, 16'h5555, 1'b1, 1'b0, 1'b0);
        check_output("frame_err_set", bus.o_frame_err, 1);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        check_output("restart_data", bus.o_data, 32'h5555);
        check_output("restart_sof", bus.o_sof, 1);
        check_output("restart_sol", bus.o_sol, 1);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        check_output("flushed_data", bus.o_data, 32'h5555);
        check_output("flushed_underrun", bus.o_underrun, 1);
        check_output("frame_err_sticky", bus.o_frame_err, 1);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        check_output("frame_err_cleared", bus.o_frame_err, 0);

        // Complete 4x3 frame on the small instance with random request gaps
        for (int p = 0; p < 12; p++) apply_small(1'b1, 16'h0A00 + 16'(p), (p == 0), 1'b0);
        for (int p = 0; p < 12; p++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) apply_small(1'b0, 16'h0, 1'b0, 1'b0);
            apply_small(1'b0, 16'h0, 1'b0, 1'b1);
            check_output($sformatf("frm_data_%0d", p), sbus.o_data, 32'h0A00 + 32'(p));
            check_output($sformatf("frm_sol_%0d", p), sbus.o_sol, (p % 4 == 0) ? 1 : 0);
            check_output($sformatf("frm_eol_%0d", p), sbus.o_eol, (p % 4 == 3) ? 1 : 0);
            check_output($sformatf("frm_sof_%0d", p), sbus.o_sof, (p == 0) ? 1 : 0);
            check_output($sformatf("frm_eof_%0d", p), sbus.o_eof, (p == 11) ? 1 : 0);
        end
        apply_small(1'b1, 16'h0B00, 1'b1, 1'b0);
        check_output("wrap_no_frame_err", sbus.o_frame_err, 0);
        apply_small(1'b0, 16'h0, 1'b0, 1'b1);
        check_output("wrap_data", sbus.o_data, 32'h0B00);
        check_output("wrap_sof", sbus.o_sof, 1);
        check_output("wrap_underrun", sbus.o_underrun, 0);
        apply_small(1'b0, 16'h0, 1'b0, 1'b0);

`ifdef KP_REQ_SOURCE_TESTPAT_EN
        // Test pattern from a fresh reset: {row[7:0], col[7:0]} for 481 pixels
        rstn = 1'b0;
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        testpat = 1'b1;
        for (int n = 0; n <= 480; n++) begin
            apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
            check_output($sformatf("pat_%0d", n), bus.o_data,
                         {16'h0, 8'(n / 480), 8'(n % 480)});
        end
        check_output("pat_no_underrun", bus.o_underrun, 0);
        testpat = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
